// File: rtl/tlb_perm_check_pipe_pkg.sv
// Shared TLB types: dirty-update FSM states and request access-type decode.
package tlb_perm_check_pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_e;

    typedef enum logic [1:0] {
        ACC_LOAD,
        ACC_STORE,
        ACC_FETCH
    } access_e;

    // Fetch wins when both store and fetch are flagged.
    function automatic access_e decode_access(input logic store, input logic fetch);
        if (fetch) begin
            return ACC_FETCH;
        end else if (store) begin
            return ACC_STORE;
        end
        return ACC_LOAD;
    endfunction

endpackage

// File: rtl/tlb_perm_check_pipe_if.sv
// Request/response, per-entry attribute and PTW dirty-request bundle for the permission checker.
interface tlb_perm_check_pipe_if #(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned CNT_W   = 16
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);

    logic               io_req_valid;
    logic               io_req_ready;
    logic               io_req_bits_store;
    logic               io_req_bits_fetch;
    logic               io_ptw_status_pum;
    logic               io_ptw_status_mxr;
    logic               priv_s;
    logic [ENTRIES-1:0] u_array;
    logic [ENTRIES-1:0] sw_array;
    logic [ENTRIES-1:0] sx_array;
    logic [ENTRIES-1:0] sr_array;
    logic [ENTRIES-1:0] xr_array;
    logic [ENTRIES-1:0] dirty_array;
    logic               prot_r;
    logic               prot_w;
    logic               prot_x;
    logic [ENTRIES:0]   hits;
    logic               bad_va;
    logic               io_resp_valid;
    logic               io_resp_xcpt_ld;
    logic               io_resp_xcpt_st;
    logic               io_resp_xcpt_if;
    logic               io_dirty_req_valid;
    logic               io_dirty_req_ready;
    logic [IDX_W-1:0]   io_dirty_req_idx;
    logic               io_dirty_ack;
    logic [CNT_W-1:0]   io_xcpt_count;

    modport slave (
        input  io_req_valid, io_req_bits_store, io_req_bits_fetch,
        input  io_ptw_status_pum, io_ptw_status_mxr, priv_s,
        input  u_array, sw_array, sx_array, sr_array, xr_array, dirty_array,
        input  prot_r, prot_w, prot_x, hits, bad_va,
        input  io_dirty_req_ready, io_dirty_ack,
        output io_req_ready, io_resp_valid, io_resp_xcpt_ld, io_resp_xcpt_st, io_resp_xcpt_if,
        output io_dirty_req_valid, io_dirty_req_idx, io_xcpt_count
    );

    modport master (
        output io_req_valid, io_req_bits_store, io_req_bits_fetch,
        output io_ptw_status_pum, io_ptw_status_mxr, priv_s,
        output u_array, sw_array, sx_array, sr_array, xr_array, dirty_array,
        output prot_r, prot_w, prot_x, hits, bad_va,
        output io_dirty_req_ready, io_dirty_ack,
        input  io_req_ready, io_resp_valid, io_resp_xcpt_ld, io_resp_xcpt_st, io_resp_xcpt_if,
        input  io_dirty_req_valid, io_dirty_req_idx, io_xcpt_count
    );

endinterface

// File: rtl/tlb_perm_comb.sv
// Combinational TLB permission check: per-access faults and lowest-index dirty-bit candidate.
module tlb_perm_comb #(
    parameter int unsigned ENTRIES = 8
) (
    input  logic                       pum,
    input  logic                       mxr,
    input  logic                       priv_s,
    input  logic [ENTRIES-1:0]         u_array,
    input  logic [ENTRIES-1:0]         sw_array,
    input  logic [ENTRIES-1:0]         sx_array,
    input  logic [ENTRIES-1:0]         sr_array,
    input  logic [ENTRIES-1:0]         xr_array,
    input  logic [ENTRIES-1:0]         dirty_array,
    input  logic                       prot_r,
    input  logic                       prot_w,
    input  logic                       prot_x,
    input  logic [ENTRIES:0]           hits,
    input  logic                       bad_va,
    output logic                       ld_fault,
    output logic                       st_fault,
    output logic                       if_fault,
    output logic                       needs_dirty,
    output logic [$clog2(ENTRIES)-1:0] hit_idx
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] priv_ok;
    logic [ENTRIES:0]   r_perm;
    logic [ENTRIES:0]   w_perm;
    logic [ENTRIES:0]   x_perm;
    logic               hit_found;

    always_comb begin
        priv_ok = priv_s ? ~(pum ? u_array : '0) : u_array;
        r_perm  = {prot_r, priv_ok & (sr_array | (mxr ? xr_array : '0))};
        w_perm  = {prot_w, priv_ok & sw_array};
        x_perm  = {prot_x, priv_ok & sx_array};

        ld_fault = bad_va | (|(~r_perm & hits));
        st_fault = bad_va | (|(~w_perm & hits));
        if_fault = bad_va | (|(~x_perm & hits));

        // Scan downward so the last assignment leaves the lowest hit index.
        hit_found = 1'b0;
        hit_idx   = '0;
        for (int unsigned i = ENTRIES; i > 0; i--) begin
            if (hits[i-1]) begin
                hit_found = 1'b1;
                hit_idx   = IDX_W'(i - 1);
            end
        end

        // The extra non-indexed entry has no dirty bit to update.
        needs_dirty = ~st_fault & ~hits[ENTRIES] & hit_found & ~dirty_array[hit_idx];
    end

endmodule

// File: rtl/tlb_perm_check_pipe.sv
// TLB permission check pipeline: 1-cycle registered response, saturating exception
// counter and a three-state PTW dirty-bit update handshake.
module tlb_perm_check_pipe
    import tlb_perm_check_pipe_pkg::*;
#(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    tlb_perm_check_pipe_if.slave  io
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             resp_valid_q, resp_valid_d;
    logic             xcpt_ld_q, xcpt_ld_d;
    logic             xcpt_st_q, xcpt_st_d;
    logic             xcpt_if_q, xcpt_if_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             ld_fault;
    logic             st_fault;
    logic             if_fault;
    logic             needs_dirty;
    logic [IDX_W-1:0] hit_idx;
    logic             accept;
    access_e          acc;

    tlb_perm_comb #(
        .ENTRIES(ENTRIES)
    ) u_perm (
        .pum        (io.io_ptw_status_pum),
        .mxr        (io.io_ptw_status_mxr),
        .priv_s     (io.priv_s),
        .u_array    (io.u_array),
        .sw_array   (io.sw_array),
        .sx_array   (io.sx_array),
        .sr_array   (io.sr_array),
        .xr_array   (io.xr_array),
        .dirty_array(io.dirty_array),
        .prot_r     (io.prot_r),
        .prot_w     (io.prot_w),
        .prot_x     (io.prot_x),
        .hits       (io.hits),
        .bad_va     (io.bad_va),
        .ld_fault   (ld_fault),
        .st_fault   (st_fault),
        .if_fault   (if_fault),
        .needs_dirty(needs_dirty),
        .hit_idx    (hit_idx)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        resp_valid_d = 1'b0;
        xcpt_ld_d    = 1'b0;
        xcpt_st_d    = 1'b0;
        xcpt_if_d    = 1'b0;
        count_d      = count_q;

        acc    = decode_access(io.io_req_bits_store, io.io_req_bits_fetch);
        accept = io.io_req_valid & (state_q == ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (accept && acc == ACC_STORE && needs_dirty) begin
                    state_d = ST_REQ;
                    idx_d   = hit_idx;
                end
            end
            ST_REQ: begin
                if (io.io_dirty_req_ready) begin
                    state_d = io.io_dirty_ack ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (io.io_dirty_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            resp_valid_d = 1'b1;
            case (acc)
                ACC_FETCH: xcpt_if_d = if_fault;
                ACC_STORE: xcpt_st_d = st_fault;
                default:   xcpt_ld_d = ld_fault;
            endcase
        end

        // Counted alongside the response register so the count already includes it.
        if ((xcpt_ld_d | xcpt_st_d | xcpt_if_d) && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            resp_valid_q <= 1'b0;
            xcpt_ld_q    <= 1'b0;
            xcpt_st_q    <= 1'b0;
            xcpt_if_q    <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            resp_valid_q <= resp_valid_d;
            xcpt_ld_q    <= xcpt_ld_d;
            xcpt_st_q    <= xcpt_st_d;
            xcpt_if_q    <= xcpt_if_d;
            count_q      <= count_d;
        end
    end

    assign io.io_req_ready       = (state_q == ST_IDLE);
    assign io.io_dirty_req_valid = (state_q == ST_REQ);
    assign io.io_dirty_req_idx   = idx_q;
    assign io.io_resp_valid      = resp_valid_q;
    assign io.io_resp_xcpt_ld    = xcpt_ld_q;
    assign io.io_resp_xcpt_st    = xcpt_st_q;
    assign io.io_resp_xcpt_if    = xcpt_if_q;
    assign io.io_xcpt_count      = count_q;

endmodule

// File: tb/tb_tlb_perm_check_pipe.sv
// Scoreboard bench for tlb_perm_check_pipe: directed requests push expected responses,
// a negedge monitor pops and compares; dirty handshake checked inline.
module tb_tlb_perm_check_pipe;

    localparam int unsigned ENTRIES = 8;
    localparam int unsigned CNT_W   = 4;

    typedef struct {
        logic       ld;
        logic       st;
        logic       ifx;
        logic [3:0] cnt;
        string      nm;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [3:0] model_cnt;
    exp_t sb[$];

    tlb_perm_check_pipe_if #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) bus ();

    tlb_perm_check_pipe #(
        .ENTRIES(ENTRIES),
        .CNT_W  (CNT_W)
    ) dut (
        .clock(clk),
        .reset(rst),
        .io   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.io_resp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'(bus.io_resp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.nm, "_ld"},  32'(bus.io_resp_xcpt_ld), 32'(e.ld));
                check({e.nm, "_st"},  32'(bus.io_resp_xcpt_st), 32'(e.st));
                check({e.nm, "_if"},  32'(bus.io_resp_xcpt_if), 32'(e.ifx));
                check({e.nm, "_cnt"}, 32'(bus.io_xcpt_count),   32'(e.cnt));
            end
        end
    end

    task automatic clear_inputs();
        bus.io_req_valid       = 1'b0;
        bus.io_req_bits_store  = 1'b0;
        bus.io_req_bits_fetch  = 1'b0;
        bus.io_ptw_status_pum  = 1'b0;
        bus.io_ptw_status_mxr  = 1'b0;
        bus.priv_s             = 1'b0;
        bus.u_array            = '0;
        bus.sw_array           = '0;
        bus.sx_array           = '0;
        bus.sr_array           = '0;
        bus.xr_array           = '0;
        bus.dirty_array        = '0;
        bus.prot_r             = 1'b0;
        bus.prot_w             = 1'b0;
        bus.prot_x             = 1'b0;
        bus.hits               = '0;
        bus.bad_va             = 1'b0;
        bus.io_dirty_req_ready = 1'b0;
        bus.io_dirty_ack       = 1'b0;
    endtask

    task automatic issue(input logic st, input logic fe, input logic eld, input logic est,
                         input logic eif, input string nm);
        int unsigned n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!bus.io_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.io_req_ready) begin
            check({nm, "_ready_timeout"}, 32'(bus.io_req_ready), 32'd1);
            return;
        end
        bus.io_req_bits_store = st;
        bus.io_req_bits_fetch = fe;
        bus.io_req_valid      = 1'b1;
        @(posedge clk);
        if ((eld | est | eif) && model_cnt != 4'hF) model_cnt = model_cnt + 4'd1;
        e.ld  = eld;
        e.st  = est;
        e.ifx = eif;
        e.cnt = model_cnt;
        e.nm  = nm;
        sb.push_back(e);
        #1 bus.io_req_valid = 1'b0;
    endtask

    // After an accept: dirty request state on the following negedge.
    task automatic check_dirty(input string nm, input logic vld, input logic [2:0] idx,
                               input logic rdy);
        check({nm, "_dvalid"}, 32'(bus.io_dirty_req_valid), 32'(vld));
        if (vld) check({nm, "_didx"}, 32'(bus.io_dirty_req_idx), 32'(idx));
        check({nm, "_rready"}, 32'(bus.io_req_ready), 32'(rdy));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout want finish");
        $fatal(1);
    end

    initial begin
        total     = 0;
        bad       = 0;
        model_cnt = 4'd0;
        clear_inputs();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_resp_valid", 32'(bus.io_resp_valid),      32'd0);
        check("rst_xcpt",       32'({bus.io_resp_xcpt_ld, bus.io_resp_xcpt_st, bus.io_resp_xcpt_if}), 32'd0);
        check("rst_dvalid",     32'(bus.io_dirty_req_valid), 32'd0);
        check("rst_idx",        32'(bus.io_dirty_req_idx),   32'd0);
        check("rst_count",      32'(bus.io_xcpt_count),      32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.io_req_ready), 32'd1);

        // User-mode load of a readable user page.
        clear_inputs();
        bus.u_array = 8'h01; bus.sr_array = 8'h01; bus.hits = 9'h001;
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "ld_user_ok");

        // Supervisor store to a user page with pum set: faults, no dirty request.
        clear_inputs();
        bus.priv_s = 1'b1; bus.io_ptw_status_pum = 1'b1;
        bus.u_array = 8'h04; bus.sw_array = 8'h04; bus.hits = 9'h004;
        issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "st_pum_fault");
        @(negedge clk);
        check_dirty("st_pum_fault", 1'b0, 3'd0, 1'b1);

        // Clean-page store: dirty request idx 3, stall ready, stray ack in REQ, then WAIT, ack.
        clear_inputs();
        bus.u_array = 8'h08; bus.sw_array = 8'h08; bus.hits = 9'h008;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "st_dirty");
        @(negedge clk);
        check_dirty("st_dirty_req", 1'b1, 3'd3, 1'b0);
        bus.io_dirty_ack = 1'b1;
        @(negedge clk);
        bus.io_dirty_ack = 1'b0;
        check_dirty("st_dirty_hold", 1'b1, 3'd3, 1'b0);
        bus.io_dirty_req_ready = 1'b1;
        @(negedge clk);
        bus.io_dirty_req_ready = 1'b0;
        check_dirty("st_dirty_wait", 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        check_dirty("st_dirty_wait2", 1'b0, 3'd0, 1'b0);
        bus.io_dirty_ack = 1'b1;
        @(negedge clk);
        bus.io_dirty_ack = 1'b0;
        check_dirty("st_dirty_done", 1'b0, 3'd0, 1'b1);

        // Fetch with mxr: execute still denied.
        clear_inputs();
        bus.io_ptw_status_mxr = 1'b1; bus.u_array = 8'hFF; bus.xr_array = 8'hFF;
        bus.hits = 9'h002;
        issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "if_mxr_fault");

        // Store+fetch: fetch wins, so no dirty request despite a clean writable page.
        clear_inputs();
        bus.u_array = 8'hFF; bus.sw_array = 8'hFF; bus.hits = 9'h001;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "st_if_prio");
        @(negedge clk);
        check_dirty("st_if_prio", 1'b0, 3'd0, 1'b1);

        // Multiple hits: lowest index, ready and ack together go straight back to idle.
        clear_inputs();
        bus.u_array = 8'hFF; bus.sw_array = 8'hFF; bus.hits = 9'h028;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "st_multi");
        @(negedge clk);
        check_dirty("st_multi_req", 1'b1, 3'd3, 1'b0);
        bus.io_dirty_req_ready = 1'b1; bus.io_dirty_ack = 1'b1;
        @(negedge clk);
        bus.io_dirty_req_ready = 1'b0; bus.io_dirty_ack = 1'b0;
        check_dirty("st_multi_done", 1'b0, 3'd0, 1'b1);

        // Extra entry: writable -> no fault, no dirty request; not writable -> fault.
        clear_inputs();
        bus.prot_w = 1'b1; bus.hits = 9'h100;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "st_extra_ok");
        @(negedge clk);
        check_dirty("st_extra_ok", 1'b0, 3'd0, 1'b1);
        bus.prot_w = 1'b0;
        issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "st_extra_fault");

        // No hit, valid VA: no fault, no dirty request.
        clear_inputs();
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "st_nohit");
        @(negedge clk);
        check_dirty("st_nohit", 1'b0, 3'd0, 1'b1);

        // Page already dirty: no dirty request.
        clear_inputs();
        bus.u_array = 8'hFF; bus.sw_array = 8'hFF; bus.dirty_array = 8'hFF; bus.hits = 9'h010;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "st_already_dirty");
        @(negedge clk);
        check_dirty("st_already_dirty", 1'b0, 3'd0, 1'b1);

        // mxr makes executable pages readable; without it the load faults.
        clear_inputs();
        bus.u_array = 8'hFF; bus.xr_array = 8'hFF; bus.io_ptw_status_mxr = 1'b1; bus.hits = 9'h020;
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "ld_mxr_ok");
        bus.io_ptw_status_mxr = 1'b0;
        issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "ld_nomxr_fault");

        // Supervisor without pum may read user pages; user mode needs u.
        clear_inputs();
        bus.priv_s = 1'b1; bus.u_array = 8'hFF; bus.sr_array = 8'hFF; bus.hits = 9'h001;
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "ld_sup_ok");
        bus.priv_s = 1'b0; bus.u_array = 8'h00;
        issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "ld_user_fault");

        // Reset while in WAIT.
        clear_inputs();
        bus.u_array = 8'hFF; bus.sw_array = 8'hFF; bus.hits = 9'h040;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "st_pre_reset");
        @(negedge clk);
        check_dirty("st_pre_reset_req", 1'b1, 3'd6, 1'b0);
        bus.io_dirty_req_ready = 1'b1;
        @(negedge clk);
        bus.io_dirty_req_ready = 1'b0;
        check_dirty("st_pre_reset_wait", 1'b0, 3'd0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst_wait_dvalid", 32'(bus.io_dirty_req_valid), 32'd0);
        check("rst_wait_idx",    32'(bus.io_dirty_req_idx),   32'd0);
        check("rst_wait_count",  32'(bus.io_xcpt_count),      32'd0);
        check("rst_wait_resp",   32'(bus.io_resp_valid),      32'd0);
        model_cnt = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("rst_wait_ready", 32'(bus.io_req_ready), 32'd1);
        bus.io_dirty_ack = 1'b1;
        @(negedge clk);
        bus.io_dirty_ack = 1'b0;
        check_dirty("rst_wait_ack_ignored", 1'b0, 3'd0, 1'b1);

        clear_inputs();
        bus.bad_va = 1'b1;
        issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "ld_bad_va");

        // Drive the 4-bit counter past saturation.
        for (int k = 0; k < 17; k++) begin
            issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "ld_sat");
        end
        repeat (3) @(negedge clk);
        check("sat_count", 32'(bus.io_xcpt_count), 32'd15);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
